// File: rtl/sd_block_responder.sv
// Serves 512-byte sd_lba/sd_rd/sd_wr/sd_ack block requests from a byte-wide image memory.
// Reads stream bytes into the requester's buffer; writes pull them from it into memory.
module sd_block_responder #(
  parameter int MEM_AW  = 24,
  parameter int BUF_LAT = 1,
  parameter int ACK_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       img_blocks,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              err_oor
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_PUT,
    S_WR_ADDR, S_WR_LAT, S_WR_REQ, S_WR_WAIT,
    S_DONE, S_GAP
  } state_t;

  localparam logic [7:0] LAT_LAST   = 8'(BUF_LAT);
  localparam int         GAP_LAST_I = (ACK_GAP > 0) ? ACK_GAP - 1 : 0;
  localparam logic [7:0] GAP_LAST   = 8'(GAP_LAST_I);

  state_t            state_r, state_s;
  logic [31:0]       lba_r, lba_s;
  logic              oor_r, oor_s;
  logic [8:0]        byte_idx_r, byte_idx_s;
  logic [7:0]        cnt_r, cnt_s;
  logic              sd_ack_r, sd_ack_s;
  logic [8:0]        sd_buff_addr_r, sd_buff_addr_s;
  logic [7:0]        sd_buff_dout_r, sd_buff_dout_s;
  logic              sd_buff_wr_r, sd_buff_wr_s;
  logic [MEM_AW-1:0] mem_addr_r, mem_addr_s;
  logic              mem_rd_r, mem_rd_s;
  logic              mem_wr_r, mem_wr_s;
  logic [7:0]        mem_wdata_r, mem_wdata_s;
  logic              err_oor_r, err_oor_s;
  logic              last_byte_s;

  assign last_byte_s = (byte_idx_r == 9'd511);

  // State and registered outputs; synchronous reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      lba_r          <= 32'd0;
      oor_r          <= 1'b0;
      byte_idx_r     <= 9'd0;
      cnt_r          <= 8'd0;
      sd_ack_r       <= 1'b0;
      sd_buff_addr_r <= 9'd0;
      sd_buff_dout_r <= 8'd0;
      sd_buff_wr_r   <= 1'b0;
      mem_addr_r     <= '0;
      mem_rd_r       <= 1'b0;
      mem_wr_r       <= 1'b0;
      mem_wdata_r    <= 8'd0;
      err_oor_r      <= 1'b0;
    end else begin
      state_r        <= state_s;
      lba_r          <= lba_s;
      oor_r          <= oor_s;
      byte_idx_r     <= byte_idx_s;
      cnt_r          <= cnt_s;
      sd_ack_r       <= sd_ack_s;
      sd_buff_addr_r <= sd_buff_addr_s;
      sd_buff_dout_r <= sd_buff_dout_s;
      sd_buff_wr_r   <= sd_buff_wr_s;
      mem_addr_r     <= mem_addr_s;
      mem_rd_r       <= mem_rd_s;
      mem_wr_r       <= mem_wr_s;
      mem_wdata_r    <= mem_wdata_s;
      err_oor_r      <= err_oor_s;
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_s        = state_r;
    lba_s          = lba_r;
    oor_s          = oor_r;
    byte_idx_s     = byte_idx_r;
    cnt_s          = cnt_r;
    sd_ack_s       = sd_ack_r;
    sd_buff_addr_s = sd_buff_addr_r;
    sd_buff_dout_s = sd_buff_dout_r;
    sd_buff_wr_s   = 1'b0;
    mem_addr_s     = mem_addr_r;
    mem_rd_s       = mem_rd_r;
    mem_wr_s       = mem_wr_r;
    mem_wdata_s    = mem_wdata_r;
    err_oor_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (sd_wr || sd_rd) begin
          lba_s      = sd_lba;
          oor_s      = (sd_lba >= img_blocks);
          err_oor_s  = (sd_lba >= img_blocks);
          sd_ack_s   = 1'b1;
          byte_idx_s = 9'd0;
          state_s    = sd_wr ? S_WR_ADDR : S_RD_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_REQ: begin
        // Out-of-range reads never touch memory and pace zeros at two cycles per byte.
        if (oor_r) begin
          sd_buff_addr_s = byte_idx_r;
          sd_buff_dout_s = 8'h00;
          sd_buff_wr_s   = 1'b1;
          state_s        = S_RD_PUT;
        end else begin
          mem_addr_s = MEM_AW'({lba_r, byte_idx_r});
          mem_rd_s   = 1'b1;
          state_s    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_ready) begin
          mem_rd_s       = 1'b0;
          sd_buff_addr_s = byte_idx_r;
          sd_buff_dout_s = mem_rdata;
          sd_buff_wr_s   = 1'b1;
          state_s        = S_RD_PUT;
        end else begin
          state_s = S_RD_WAIT;
        end
      end
      S_RD_PUT: begin
        if (last_byte_s) begin
          sd_ack_s = 1'b0;
          state_s  = S_DONE;
        end else begin
          byte_idx_s = byte_idx_r + 9'd1;
          state_s    = S_RD_REQ;
        end
      end
      S_WR_ADDR: begin
        sd_buff_addr_s = byte_idx_r;
        cnt_s          = 8'd0;
        state_s        = S_WR_LAT;
      end
      S_WR_LAT: begin
        // Buffer data is valid on the (BUF_LAT+1)th edge after the address was presented.
        if (cnt_r == LAT_LAST) begin
          mem_wdata_s = sd_buff_din;
          state_s     = S_WR_REQ;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_WR_REQ: begin
        if (oor_r) begin
          if (last_byte_s) begin
            sd_ack_s = 1'b0;
            state_s  = S_DONE;
          end else begin
            byte_idx_s = byte_idx_r + 9'd1;
            state_s    = S_WR_ADDR;
          end
        end else begin
          mem_addr_s = MEM_AW'({lba_r, byte_idx_r});
          mem_wr_s   = 1'b1;
          state_s    = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (mem_ready) begin
          mem_wr_s = 1'b0;
          if (last_byte_s) begin
            sd_ack_s = 1'b0;
            state_s  = S_DONE;
          end else begin
            byte_idx_s = byte_idx_r + 9'd1;
            state_s    = S_WR_ADDR;
          end
        end else begin
          state_s = S_WR_WAIT;
        end
      end
      S_DONE: begin
        cnt_s   = 8'd0;
        state_s = S_GAP;
      end
      S_GAP: begin
        if (cnt_r >= GAP_LAST) begin
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s  = S_IDLE;
        sd_ack_s = 1'b0;
        mem_rd_s = 1'b0;
        mem_wr_s = 1'b0;
      end
    endcase
  end

  assign sd_ack       = sd_ack_r;
  assign sd_buff_addr = sd_buff_addr_r;
  assign sd_buff_dout = sd_buff_dout_r;
  assign sd_buff_wr   = sd_buff_wr_r;
  assign mem_addr     = mem_addr_r;
  assign mem_rd       = mem_rd_r;
  assign mem_wr       = mem_wr_r;
  assign mem_wdata    = mem_wdata_r;
  assign err_oor      = err_oor_r;

endmodule
